// File: rtl/cla_addsub_iter.sv
// rtl/cla_addsub_iter.sv - iterative chunked carry-lookahead adder/subtractor
//
// Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, using a
// single carry-lookahead slice reused NCHUNK = WIDTH/CHUNK times.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b, cin, sub       operands; sub=0: a+b+cin, sub=1: a-b (cin ignored)
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   sum, cout            result and carry out of MSB (sub: 1 = no borrow)
//   overflow, zero       signed overflow, sum == 0
module cla_addsub_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (CHUNK < 1 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
    $error("cla_addsub_iter: need CHUNK >= 1, WIDTH >= 2, WIDTH %% CHUNK == 0");
  end

  logic [1:0]       state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Lookahead slice on the current chunk.
  logic [CHUNK-1:0] a_c, b_c, g_c, p_c, s_c;
  logic [CHUNK:0]   c_c;
  logic             term, pp;
  int               base;

  always_comb begin
    base = int'(k_q) * CHUNK;
    a_c  = a_q[base +: CHUNK];
    b_c  = b_q[base +: CHUNK];
    g_c  = a_c & b_c;
    p_c  = a_c ^ b_c;
    c_c  = '0;
    c_c[0] = carry_q;
    term = 1'b0;
    pp   = 1'b0;
    // Each carry is the flat sum-of-products of generates and the chunk
    // carry-in, not a chain through the previous carry.
    for (int i = 0; i < CHUNK; i++) begin
      term = g_c[i];
      pp   = p_c[i];
      for (int j = i - 1; j >= 0; j--) begin
        term = term | (pp & g_c[j]);
        pp   = pp & p_c[j];
      end
      c_c[i+1] = term | (pp & carry_q);
    end
    s_c = p_c ^ c_c[CHUNK-1:0];
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub ? 1'b1 : cin;
          k_d     = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d[base +: CHUNK] = s_c;
        carry_d = c_c[CHUNK];
        k_d     = k_q + KW'(1);
        if (k_q == KW'(NCHUNK - 1)) begin
          // Published outputs change only here, so they hold their last
          // completed values through IDLE and the next BUSY phase.
          sum_d   = acc_d;
          cout_d  = c_c[CHUNK];
          ovf_d   = c_c[CHUNK-1] ^ c_c[CHUNK];
          zero_d  = (acc_d == '0);
          k_d     = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_cla_addsub_iter.sv
// tb/tb_cla_addsub_iter.sv - directed self-checking bench for cla_addsub_iter
module tb_cla_addsub_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0, sub = 1'b0;

  logic        in_valid = 1'b0, out_ready = 1'b0, in_ready, out_valid;
  logic [31:0] sum;
  logic        cout, overflow, zero;

  logic        iv_w = 1'b0, or_w = 1'b0, ir_w, ov_w;
  logic [31:0] sum_w;
  logic        cout_w, ovf_w, zero_w;

  logic        iv_b = 1'b0, or_b = 1'b0, ir_b, ov_b;
  logic [31:0] sum_b;
  logic        cout_b, ovf_b, zero_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cla_addsub_iter #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  cla_addsub_iter #(.WIDTH(32), .CHUNK(32)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_w), .in_ready(ir_w),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov_w),
    .out_ready(or_w), .sum(sum_w), .cout(cout_w), .overflow(ovf_w), .zero(zero_w)
  );

  cla_addsub_iter #(.WIDTH(32), .CHUNK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_b), .in_ready(ir_b),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov_b),
    .out_ready(or_b), .sum(sum_b), .cout(cout_b), .overflow(ovf_b), .zero(zero_b)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tc, input logic ts,
                        output logic [31:0] rs, output logic rc,
                        output logic ro, output logic rz, output int lat);
    @(negedge clk);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    rs = sum; rc = cout; ro = overflow; rz = zero;
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({in_ready, out_valid, sum, cout, overflow, zero} !== {1'b1, 1'b0, 32'h0, 3'b000}) begin
      bad++;
      $display("FAIL reset_main got=%h exp=%h", {in_ready, out_valid, sum, cout, overflow, zero},
               {1'b1, 1'b0, 32'h0, 3'b000});
    end
    total++;
    if ({ir_w, ov_w, sum_w, ir_b, ov_b, sum_b} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0}) begin
      bad++;
      $display("FAIL reset_alt got=%h exp=%h", {ir_w, ov_w, sum_w, ir_b, ov_b, sum_b},
               {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    vec_t        v [0:9];
    logic [31:0] rs;
    logic        rc, ro, rz;
    int          lat;
    v[0] = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0, 1'b0};
    v[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
    v[2] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    v[3] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
    v[4] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    v[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    v[6] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
    v[7] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
    v[8] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};
    v[9] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      run_op(v[i].a, v[i].b, v[i].cin, v[i].sub, rs, rc, ro, rz, lat);
      total++;
      if ({rs, rc, ro, rz} !== {v[i].s, v[i].c, v[i].o, v[i].z}) begin
        bad++;
        $display("FAIL vec%0d result got=%h/%b%b%b exp=%h/%b%b%b", i, rs, rc, ro, rz,
                 v[i].s, v[i].c, v[i].o, v[i].z);
      end
      total++;
      if (lat !== 4) begin
        bad++;
        $display("FAIL vec%0d latency got=%0d exp=4", i, lat);
      end
      drain();
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
        bad++;
        $display("FAIL vec%0d drain got=%b exp=10", i, {in_ready, out_valid});
      end
    end
  endtask

  task automatic test_hold();
    logic [31:0] rs;
    logic        rc, ro, rz;
    int          lat;
    run_op(32'h10, 32'h20, 1'b0, 1'b0, rs, rc, ro, rz, lat);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 32'hDEADBEEF; b = 32'h1; sub = 1'b0; cin = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({out_valid, in_ready, sum, cout, overflow, zero} !== {1'b1, 1'b0, 32'h30, 3'b000}) begin
        bad++;
        $display("FAIL hold%0d got=%h exp=%h", i, {out_valid, in_ready, sum, cout, overflow, zero},
                 {1'b1, 1'b0, 32'h30, 3'b000});
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 32'h30}) begin
      bad++;
      $display("FAIL hold_release got=%h exp=%h", {out_valid, in_ready, sum}, {1'b0, 1'b1, 32'h30});
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({in_ready, out_valid, sum} !== {1'b1, 1'b0, 32'h30}) begin
      bad++;
      $display("FAIL hold_not_taken got=%h exp=%h", {in_ready, out_valid, sum}, {1'b1, 1'b0, 32'h30});
    end
  endtask

  task automatic test_reset_busy();
    logic [31:0] rs;
    logic        rc, ro, rz;
    int          lat;
    logic        seen;
    @(negedge clk);
    a = 32'h1; b = 32'h2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 32'h0}) begin
      bad++;
      $display("FAIL rst_busy got=%h exp=%h", {out_valid, in_ready, sum}, {1'b0, 1'b1, 32'h0});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_stale got=%b exp=0", seen);
    end
    run_op(32'h1, 32'h2, 1'b0, 1'b0, rs, rc, ro, rz, lat);
    total++;
    if ({rs, lat} !== {32'h3, 32'd4}) begin
      bad++;
      $display("FAIL rst_after got=%h/%0d exp=3/4", rs, lat);
    end
    drain();
  endtask

  task automatic test_builds();
    logic [31:0] ta, tb_, es, cs_w, cs_b;
    logic        tc, ts, ec, eo, ez;
    logic [32:0] wide;
    logic [2:0]  fw, fb;
    int          n, lw, lb;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0: begin ta = 32'hFFFFFFFF; tb_ = 32'h0;        tc = 1'b1; ts = 1'b0; end
        1: begin ta = 32'h7FFFFFFF; tb_ = 32'hFFFFFFFF; tc = 1'b0; ts = 1'b1; end
        2: begin ta = 32'h00000003; tb_ = 32'h00000007; tc = 1'b1; ts = 1'b1; end
        default: begin ta = $urandom; tb_ = $urandom; tc = 1'($urandom); ts = 1'($urandom); end
      endcase
      if (ts) begin
        es = ta - tb_;
        ec = (ta >= tb_);
        eo = (ta[31] != tb_[31]) && (es[31] != ta[31]);
      end else begin
        wide = {1'b0, ta} + {1'b0, tb_} + {32'h0, tc};
        es = wide[31:0];
        ec = wide[32];
        eo = (ta[31] == tb_[31]) && (es[31] != ta[31]);
      end
      ez = (es == 32'h0);
      @(negedge clk);
      a = ta; b = tb_; cin = tc; sub = ts; iv_w = 1'b1; iv_b = 1'b1;
      @(posedge clk); #1;
      iv_w = 1'b0; iv_b = 1'b0;
      n = 0; lw = -1; lb = -1;
      cs_w = '0; cs_b = '0; fw = '0; fb = '0;
      while ((lw < 0 || lb < 0) && n < 60) begin
        @(posedge clk); #1;
        n++;
        if (lw < 0 && ov_w === 1'b1) begin
          lw = n; cs_w = sum_w; fw = {cout_w, ovf_w, zero_w};
        end
        if (lb < 0 && ov_b === 1'b1) begin
          lb = n; cs_b = sum_b; fb = {cout_b, ovf_b, zero_b};
        end
      end
      total++;
      if (lw !== 1) begin
        bad++;
        $display("FAIL build32_lat%0d got=%0d exp=1", i, lw);
      end
      total++;
      if (lb !== 32) begin
        bad++;
        $display("FAIL build1_lat%0d got=%0d exp=32", i, lb);
      end
      total++;
      if ({cs_w, fw} !== {es, ec, eo, ez}) begin
        bad++;
        $display("FAIL build32_res%0d got=%h/%b exp=%h/%b%b%b", i, cs_w, fw, es, ec, eo, ez);
      end
      total++;
      if ({cs_b, fb} !== {es, ec, eo, ez}) begin
        bad++;
        $display("FAIL build1_res%0d got=%h/%b exp=%h/%b%b%b", i, cs_b, fb, es, ec, eo, ez);
      end
      @(negedge clk);
      or_w = 1'b1; or_b = 1'b1;
      @(posedge clk); #1;
      or_w = 1'b0; or_b = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_vectors();
    test_hold();
    test_reset_busy();
    test_builds();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
